// File: rtl/snake_sprite_pkg.sv
// Shared types and default geometry for the sprite ROM fetch path.
// A tile is 2^(ADDR_W-TILE_W) RGB565 words of the 1024-word sprite ROM.
package snake_sprite_pkg;

  localparam int ADDR_W     = 10;
  localparam int DATA_W     = 16;
  localparam int TILE_W     = 2;
  localparam int TILE_WORDS = 1 << (ADDR_W - TILE_W);

  typedef enum logic [1:0] {
    IDLE,
    STREAM,
    DRAIN
  } fetch_state_t;

  typedef enum logic [1:0] {
    NONE,
    PORT_A,
    PORT_B
  } issuer_t;

endpackage

// File: rtl/snake_skid_fifo.sv
// Two-entry {last, data} FIFO feeding the tile-burst sink.
// An empty FIFO passes the incoming word straight to its output.
module snake_skid_fifo #(
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push_i,
  input  logic              push_last_i,
  input  logic [DATA_W-1:0] push_data_i,
  input  logic              pop_i,
  output logic              valid_o,
  output logic              last_o,
  output logic [DATA_W-1:0] data_o,
  output logic [1:0]        count_o
);

  logic [DATA_W:0] mem_q [2];
  logic            rd_ptr_q, rd_ptr_d;
  logic [1:0]      count_q, count_d;
  logic            store, drop, wr_ptr;

  always_comb begin
    valid_o = (count_q != 2'd0) || push_i;
    {last_o, data_o} = (count_q != 2'd0) ? mem_q[rd_ptr_q] : {push_last_i, push_data_i};
    // A word consumed in the same cycle it arrives never needs a slot.
    store    = push_i && !((count_q == 2'd0) && pop_i);
    drop     = pop_i && (count_q != 2'd0);
    wr_ptr   = rd_ptr_q ^ count_q[0];
    count_d  = count_q + 2'(store) - 2'(drop);
    rd_ptr_d = rd_ptr_q ^ drop;
    count_o  = count_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q  <= 2'd0;
      rd_ptr_q <= 1'b0;
    end else begin
      count_q  <= count_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (store) begin
      mem_q[wr_ptr] <= {push_last_i, push_data_i};
    end
  end

endmodule

// File: rtl/snake_sprite_fetch.sv
// Shares the single-port sprite ROM between the fixed-latency pixel port (A)
// and the backpressured tile-burst port (B), with a starvation guard for B.
module snake_sprite_fetch #(
  parameter int ADDR_W    = snake_sprite_pkg::ADDR_W,
  parameter int DATA_W    = snake_sprite_pkg::DATA_W,
  parameter int TILE_W    = snake_sprite_pkg::TILE_W,
  parameter int MAX_STALL = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              a_req,
  input  logic [ADDR_W-1:0] a_addr,
  output logic              a_gnt,
  output logic              a_rvalid,
  output logic [DATA_W-1:0] a_rdata,
  input  logic              b_start,
  input  logic [TILE_W-1:0] b_tile,
  output logic              b_busy,
  output logic              b_valid,
  input  logic              b_ready,
  output logic [DATA_W-1:0] b_data,
  output logic              b_last,
  output logic              rom_ce,
  output logic              rom_oce,
  output logic              rom_reset,
  output logic [ADDR_W-1:0] rom_ad,
  input  logic [DATA_W-1:0] rom_dout
);

  import snake_sprite_pkg::*;

  localparam int OFF_W   = ADDR_W - TILE_W;
  localparam int STALL_W = $clog2(MAX_STALL + 1);

  fetch_state_t        state_q, state_d;
  issuer_t             tag_q, tag_d;
  logic                tag_last_q, tag_last_d;
  logic [TILE_W-1:0]   tile_q, tile_d;
  logic [OFF_W-1:0]    ptr_q, ptr_d;
  logic [OFF_W:0]      cnt_q, cnt_d;
  logic [STALL_W-1:0]  stall_q, stall_d;

  logic                fifo_valid, fifo_last;
  logic [DATA_W-1:0]   fifo_data;
  logic [1:0]          fifo_count;
  logic                ret_b, b_pop, b_elig, force_b, grant_a, issue_b;
  logic [2:0]          pending;

  snake_skid_fifo #(.DATA_W(DATA_W)) u_fifo (
    .clk         (clk),
    .reset       (reset),
    .push_i      (ret_b),
    .push_last_i (tag_last_q),
    .push_data_i (rom_dout),
    .pop_i       (b_pop),
    .valid_o     (fifo_valid),
    .last_o      (fifo_last),
    .data_o      (fifo_data),
    .count_o     (fifo_count)
  );

  // Words owned by B but not yet consumed: buffered plus the one on the ROM bus.
  always_comb begin
    ret_b   = !reset && (tag_q == PORT_B);
    pending = {1'b0, fifo_count} + {2'b00, (tag_q == PORT_B)};
    b_elig  = (state_q == STREAM) && (pending < 3'd2);
    force_b = (stall_q == STALL_W'(MAX_STALL));
    grant_a = !reset && a_req && !force_b;
    issue_b = !reset && !grant_a && b_elig;
    b_valid = !reset && fifo_valid;
    b_pop   = b_valid && b_ready;
  end

  always_comb begin
    state_d    = state_q;
    tile_d     = tile_q;
    ptr_d      = ptr_q;
    cnt_d      = cnt_q;
    stall_d    = stall_q;
    tag_d      = NONE;
    tag_last_d = 1'b0;

    if (grant_a) begin
      tag_d = PORT_A;
      if (b_elig) begin
        stall_d = stall_q + 1'b1;
      end
    end else if (issue_b) begin
      tag_d      = PORT_B;
      tag_last_d = &ptr_q;
      ptr_d      = ptr_q + 1'b1;
      cnt_d      = cnt_q + 1'b1;
      stall_d    = '0;
    end

    case (state_q)
      IDLE: begin
        if (b_start) begin
          state_d = STREAM;
          tile_d  = b_tile;
          ptr_d   = '0;
          cnt_d   = '0;
          stall_d = '0;
        end
      end
      STREAM: begin
        if (issue_b && (cnt_q == (OFF_W+1)'((1 << OFF_W) - 1))) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (pending == {2'b00, b_pop}) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    a_gnt     = grant_a;
    a_rvalid  = !reset && (tag_q == PORT_A);
    a_rdata   = a_rvalid ? rom_dout : '0;
    b_busy    = (state_q != IDLE);
    b_data    = b_valid ? fifo_data : '0;
    b_last    = b_valid && fifo_last;
    rom_ce    = grant_a || issue_b;
    rom_oce   = 1'b1;
    rom_reset = reset;
    rom_ad    = '0;
    if (grant_a) begin
      rom_ad = a_addr;
    end else if (issue_b) begin
      rom_ad = {tile_q, ptr_q};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      tag_q      <= NONE;
      tag_last_q <= 1'b0;
      tile_q     <= '0;
      ptr_q      <= '0;
      cnt_q      <= '0;
      stall_q    <= '0;
    end else begin
      state_q    <= state_d;
      tag_q      <= tag_d;
      tag_last_q <= tag_last_d;
      tile_q     <= tile_d;
      ptr_q      <= ptr_d;
      cnt_q      <= cnt_d;
      stall_q    <= stall_d;
    end
  end

endmodule
